bip_exec_ctrl: RTL

Instruction sequencer and operand stage that sits directly upstream of the accumulator (`acc`). It fetches 16-bit instructions from program memory, reads data memory, and computes the next accumulator value. It drives the accumulator's `in_data` and `enable` ports and consumes its `out_data`. It executes the BIP-I instruction set at a fixed 3 cycles per instruction.

---
 rtl/bip_pkg.sv | 31 +++
 rtl/bip_operand_alu.sv | 30 +++
 rtl/bip_exec_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP-I execution controller: opcodes, FSM states,
// instruction layout and default widths.
package bip_pkg;

    localparam int DEF_PC_W   = 11;
    localparam int DEF_DATA_W = 16;
    localparam int OPC_W      = 5;
    localparam int OPND_W     = 11;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'd0;
    localparam logic [OPC_W-1:0] OP_STO  = 5'd1;
    localparam logic [OPC_W-1:0] OP_LD   = 5'd2;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'd3;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd4;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd6;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'd7;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [OPND_W-1:0] operand;
    } instr_t;

endpackage

// File: rtl/bip_operand_alu.sv
// Combinational next-accumulator datapath; load is set for every opcode that
// writes the accumulator.
module bip_operand_alu
    import bip_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] acc_q,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] acc_in,
    output logic              load
);

    always_comb begin
        acc_in = '0;
        load   = 1'b0;
        case (opcode)
            OP_LD:   begin acc_in = ram_rdata;         load = 1'b1; end
            OP_LDI:  begin acc_in = imm;               load = 1'b1; end
            OP_ADD:  begin acc_in = acc_q + ram_rdata; load = 1'b1; end
            OP_ADDI: begin acc_in = acc_q + imm;       load = 1'b1; end
            OP_SUB:  begin acc_in = acc_q - ram_rdata; load = 1'b1; end
            OP_SUBI: begin acc_in = acc_q - imm;       load = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_exec_ctrl.sv
// BIP-I sequencer: FETCH/DECODE/EXEC at 3 cycles per instruction, HLT parks in HALT.
// Optional BIP_CYCLE_COUNT_EN adds a saturating cycle_count output.
module bip_exec_ctrl
    import bip_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] acc_q,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] acc_in,
    output logic              acc_en,
    output logic              halted
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [DATA_W-1:0] cycle_count
`endif
);

    state_t            state;
    instr_t            ir;
    instr_t            instr_w;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_acc_in;
    logic              alu_load;
    logic              exec;

    assign instr_w = instr_t'(instr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    ir    <= instr_w;
                    state <= (instr_w.opcode == OP_HLT) ? HALT : EXEC;
                end
                EXEC: begin
                    pc    <= pc + 1'b1;
                    state <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    // Data memory is a 1-cycle synchronous read, so the operand must be on the
    // bus during DECODE for ram_rdata to be valid in EXEC.
    assign ram_addr  = (state == DECODE) ? PC_W'(instr_w.operand) : PC_W'(ir.operand);
    assign ram_wdata = acc_q;
    assign imm       = {{(DATA_W-OPND_W){ir.operand[OPND_W-1]}}, ir.operand};

    bip_operand_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode    (ir.opcode),
        .acc_q     (acc_q),
        .ram_rdata (ram_rdata),
        .imm       (imm),
        .acc_in    (alu_acc_in),
        .load      (alu_load)
    );

    // Gating with reset kills a strobe in the very cycle reset rises.
    assign exec   = (state == EXEC) && !reset;
    assign acc_en = exec && alu_load;
    assign ram_we = exec && (ir.opcode == OP_STO);
    assign acc_in = exec ? alu_acc_in : '0;
    assign halted = (state == HALT);

`ifdef BIP_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            cycle_count <= '0;
        else if (state != HALT && !(&cycle_count))
            cycle_count <= cycle_count + 1'b1;
    end
`endif

endmodule
